axi_lite_slave_mem: RTL and testbench
=====================================

# axi_lite_slave_mem

AXI-Lite memory-mapped slave endpoint that sits directly downstream of one slave port of the priority AXI-Lite interconnect and terminates its transactions. It owns one address window (offset/range, the same encoding the interconnect uses for its slave map). It also holds a word-addressed register array with byte strobes and returns responses after a fixed, programmable latency. Instances of it populate the slave side of the interconnect in system builds and benches.

## Interface
- AXI_DATA_WIDTH, 32, data bus width (32 only; byte lanes = 4)
- AXI_ADDR_WIDTH, 32, address bus width
- AXI_ADDR_OFFSET, 32'h0000_0000, base of this slave's window
- AXI_ADDR_RANGE, 32'h0FFF_FFFF, window size minus one
- MEM_DEPTH, 256, number of 32-bit words backed by storage (power of two)
- RESP_DELAY, 2, idle cycles between request completion and response valid (0..15)

- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, asynchronous assert, active-low
- s_axil_awaddr / awvalid / awready  in/in/out  32/1/1  write address channel
- s_axil_wdata / wstrb / wvalid / wready  in/in/in/out  32/4/1/1  write data channel
- s_axil_bresp / bvalid / bready  out/out/in  2/1/1  write response channel
- s_axil_araddr / arvalid / arready  in/in/out  32/1/1  read address channel
- s_axil_rdata / rresp / rvalid / rready  out/out/out/in  32/2/1/1  read data channel

## Operation
- Write and read paths are independent FSMs; both may be active simultaneously.
- Write FSM: W_IDLE -> W_WAIT -> W_RESP -> W_IDLE.
  - In W_IDLE, awready and wready are high for each channel not yet captured.
  - AW and W are captured independently, in either order or in the same cycle. A captured channel drops its ready.
  - When both channels are held, the FSM commits the write (if OKAY), loads the delay counter with RESP_DELAY, and enters W_WAIT.
  - W_WAIT counts down. At zero the FSM enters W_RESP with bvalid=1.
  - In W_RESP, bvalid and bresp hold until bready. On handshake the FSM returns to W_IDLE with both readies high the next cycle.
- Read FSM: R_IDLE (arready=1) -> R_WAIT -> R_RESP -> R_IDLE.
  - Capture araddr, count down RESP_DELAY, then sample the array into rdata on entering R_RESP.
  - In R_RESP, rvalid, rdata and rresp hold until rready.
- Decode (identical for both paths):
  - in_window = (addr >= OFFSET) && (addr - OFFSET <= RANGE), computed as a 33-bit compare with no wrap.
  - idx = (addr - OFFSET) >> 2; addr[1:0] is ignored.
  - Outside window -> DECERR 2'b11. In window with idx >= MEM_DEPTH -> SLVERR 2'b10. Otherwise -> OKAY 2'b00.
- Writes with a non-OKAY response leave the array untouched. On an OKAY write, only byte lanes with wstrb[i]=1 are updated; wstrb=0 is OKAY with no change.
- Reads with a non-OKAY response return rdata=0.
- Same-cycle write commit and read sample to the same idx: the read returns pre-write data.
- The array is not reset; its contents are undefined until written.

## Timing
- Reset values (async, while aresetn=0):
  - awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=2'b00, rdata=0.
  - FSMs go to IDLE and captured flags clear.
- Readies rise on the first rising edge after aresetn deasserts.
- Write latency: the later of the AW/W handshakes occurs at edge k. bvalid is high from edge k+1+RESP_DELAY.
- Read latency: the AR handshake occurs at edge k. rvalid is high from edge k+1+RESP_DELAY. RESP_DELAY=0 gives a one-cycle response.
- Throughput: one outstanding transaction per direction. A new AW/W/AR is accepted only in IDLE, i.e. the cycle after the B/R handshake.
- Valid and payload never change while valid=1 and ready=0. Behaviour is independent of the ready level before valid.
- Reset asserted mid-transaction aborts it immediately with no response. An uncommitted write leaves the array unchanged.

## Test plan
- Write 32'hDEAD_BEEF to OFFSET+0x10 with strobe 4'hF, then read OFFSET+0x10 -> bresp=00, rdata=32'hDEAD_BEEF, rresp=00. With RESP_DELAY=2, bvalid rises 3 cycles after the last of AW/W.
- W presented 4 cycles before AW; then a strobe-only write of 32'h1122_3344 with wstrb=4'b0101 over 32'hDEAD_BEEF -> single B response; readback = 32'hDE22_BE44.
- Read at OFFSET+4*MEM_DEPTH -> rresp=10, rdata=0. Write at OFFSET+RANGE+1 -> bresp=11 and the array is unchanged.
- Hold bready/rready low for 10 cycles with a simultaneous write and read to the same idx -> B/R payloads stay stable and are accepted on the ready edge; the read returns old data if its sample coincides with the commit.
- Assert aresetn low while in W_WAIT -> all outputs reach reset values asynchronously; after release, no stale bvalid appears and the target word is unchanged.

Source files
------------

// File: rtl/axi_lite_slave_mem_if.sv
// AXI-Lite bundle between one interconnect slave port and an endpoint.
// The master modport is the interconnect side, the slave modport the endpoint.
interface axi_lite_slave_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] s_axil_awaddr;
    logic              s_axil_awvalid;
    logic              s_axil_awready;
    logic [DATA_W-1:0] s_axil_wdata;
    logic [STRB_W-1:0] s_axil_wstrb;
    logic              s_axil_wvalid;
    logic              s_axil_wready;
    logic [1:0]        s_axil_bresp;
    logic              s_axil_bvalid;
    logic              s_axil_bready;
    logic [ADDR_W-1:0] s_axil_araddr;
    logic              s_axil_arvalid;
    logic              s_axil_arready;
    logic [DATA_W-1:0] s_axil_rdata;
    logic [1:0]        s_axil_rresp;
    logic              s_axil_rvalid;
    logic              s_axil_rready;

    modport master (
        output s_axil_awaddr, s_axil_awvalid, input s_axil_awready,
        output s_axil_wdata, s_axil_wstrb, s_axil_wvalid, input s_axil_wready,
        input  s_axil_bresp, s_axil_bvalid, output s_axil_bready,
        output s_axil_araddr, s_axil_arvalid, input s_axil_arready,
        input  s_axil_rdata, s_axil_rresp, s_axil_rvalid, output s_axil_rready
    );

    modport slave (
        input  s_axil_awaddr, s_axil_awvalid, output s_axil_awready,
        input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid, output s_axil_wready,
        output s_axil_bresp, s_axil_bvalid, input s_axil_bready,
        input  s_axil_araddr, s_axil_arvalid, output s_axil_arready,
        output s_axil_rdata, s_axil_rresp, s_axil_rvalid, input s_axil_rready
    );
endinterface

// File: rtl/axi_lite_slave_mem.sv
// AXI-Lite memory endpoint: one address window backed by a byte-strobed word
// array, with independent write/read FSMs and a fixed response delay.
module axi_lite_slave_mem #(
    parameter int                        AXI_DATA_WIDTH  = 32,
    parameter int                        AXI_ADDR_WIDTH  = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_OFFSET = 32'h0000_0000,
    parameter logic [AXI_ADDR_WIDTH-1:0] AXI_ADDR_RANGE  = 32'h0FFF_FFFF,
    parameter int                        MEM_DEPTH       = 256,
    parameter int                        RESP_DELAY      = 2
) (
    input logic                 aclk,
    input logic                 aresetn,
    axi_lite_slave_mem_if.slave s_axil
);
    localparam int AW    = AXI_ADDR_WIDTH;
    localparam int DW    = AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = $clog2(MEM_DEPTH);

    // One extra bit so window arithmetic never wraps.
    localparam logic [AW:0] OFF_X   = {1'b0, AXI_ADDR_OFFSET};
    localparam logic [AW:0] RNG_X   = {1'b0, AXI_ADDR_RANGE};
    localparam logic [AW:0] DEPTH_X = (AW+1)'(MEM_DEPTH);
    localparam logic [3:0]  DELAY   = 4'(RESP_DELAY);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_e;

    function automatic logic [1:0] decode_resp(input logic [AW-1:0] addr);
        logic [AW:0] addr_x;
        logic [AW:0] word_off;
        logic [1:0]  resp;
        addr_x   = {1'b0, addr};
        word_off = (addr_x - OFF_X) >> 2'd2;
        if ((addr_x < OFF_X) || ((addr_x - OFF_X) > RNG_X)) begin
            resp = RESP_DECERR;
        end else if (word_off >= DEPTH_X) begin
            resp = RESP_SLVERR;
        end else begin
            resp = RESP_OKAY;
        end
        return resp;
    endfunction

    function automatic logic [IDX_W-1:0] decode_idx(input logic [AW-1:0] addr);
        return IDX_W'(({1'b0, addr} - OFF_X) >> 2'd2);
    endfunction

    logic [DW-1:0] mem [MEM_DEPTH];

    w_state_e      w_state_q, w_state_d;
    logic          aw_held_q, aw_held_d;
    logic          w_held_q, w_held_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic [3:0]    w_cnt_q, w_cnt_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          bvalid_q, bvalid_d;
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;

    r_state_e      r_state_q, r_state_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic [3:0]    r_cnt_q, r_cnt_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          arready_q, arready_d;

    logic             aw_hs_s, w_hs_s, ar_hs_s;
    logic             aw_have_s, w_have_s;
    logic [AW-1:0]    wr_addr_s;
    logic [DW-1:0]    wr_data_s;
    logic [SW-1:0]    wr_strb_s;
    logic [1:0]       wr_resp_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic             mem_we_s;
    logic [1:0]       rd_resp_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [DW-1:0]    rd_word_s;

    assign aw_hs_s   = s_axil.s_axil_awvalid & awready_q;
    assign w_hs_s    = s_axil.s_axil_wvalid & wready_q;
    assign ar_hs_s   = s_axil.s_axil_arvalid & arready_q;
    assign aw_have_s = aw_held_q | aw_hs_s;
    assign w_have_s  = w_held_q | w_hs_s;

    // A channel captured in an earlier cycle wins over the live bus value.
    assign wr_addr_s = aw_held_q ? awaddr_q : s_axil.s_axil_awaddr;
    assign wr_data_s = w_held_q ? wdata_q : s_axil.s_axil_wdata;
    assign wr_strb_s = w_held_q ? wstrb_q : s_axil.s_axil_wstrb;
    assign wr_resp_s = decode_resp(wr_addr_s);
    assign wr_idx_s  = decode_idx(wr_addr_s);

    assign rd_resp_s = decode_resp(araddr_q);
    assign rd_idx_s  = decode_idx(araddr_q);
    assign rd_word_s = mem[rd_idx_s];

    // Write FSM next-state: capture AW/W independently, commit once both are held.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        w_cnt_d   = w_cnt_q;
        bresp_d   = bresp_q;
        mem_we_s  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s) begin
                    awaddr_d  = s_axil.s_axil_awaddr;
                    aw_held_d = 1'b1;
                end else begin
                    awaddr_d = awaddr_q;
                end
                if (w_hs_s) begin
                    wdata_d  = s_axil.s_axil_wdata;
                    wstrb_d  = s_axil.s_axil_wstrb;
                    w_held_d = 1'b1;
                end else begin
                    wdata_d = wdata_q;
                end
                if (aw_have_s && w_have_s) begin
                    mem_we_s  = (wr_resp_s == RESP_OKAY);
                    bresp_d   = wr_resp_s;
                    w_cnt_d   = DELAY;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_WAIT;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == 4'd0) begin
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (s_axil.s_axil_bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
            end
        endcase
        bvalid_d  = (w_state_d == W_RESP);
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // Read FSM next-state: the array is sampled on the edge entering R_RESP.
    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        r_cnt_d   = r_cnt_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    araddr_d  = s_axil.s_axil_araddr;
                    r_cnt_d   = DELAY;
                    r_state_d = R_WAIT;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    r_state_d = R_RESP;
                    rresp_d   = rd_resp_s;
                    rdata_d   = (rd_resp_s == RESP_OKAY) ? rd_word_s : {DW{1'b0}};
                end else begin
                    r_cnt_d = r_cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (s_axil.s_axil_rready) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_RESP;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
        rvalid_d  = (r_state_d == R_RESP);
        arready_d = (r_state_d == R_IDLE);
    end

    // Write-path state and registered write-channel outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= {AW{1'b0}};
            wdata_q   <= {DW{1'b0}};
            wstrb_q   <= {SW{1'b0}};
            w_cnt_q   <= 4'd0;
            bresp_q   <= 2'b00;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            w_cnt_q   <= w_cnt_d;
            bresp_q   <= bresp_d;
            bvalid_q  <= bvalid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    // Read-path state and registered read-channel outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            araddr_q  <= {AW{1'b0}};
            r_cnt_q   <= 4'd0;
            rresp_q   <= 2'b00;
            rdata_q   <= {DW{1'b0}};
            rvalid_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            r_cnt_q   <= r_cnt_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
        end
    end

    // Byte-lane write port; storage is deliberately left unreset.
    always_ff @(posedge aclk) begin
        if (mem_we_s) begin
            for (int b = 0; b < SW; b++) begin
                if (wr_strb_s[b]) begin
                    mem[wr_idx_s][8*b +: 8] <= wr_data_s[8*b +: 8];
                end
            end
        end
    end

    assign s_axil.s_axil_awready = awready_q;
    assign s_axil.s_axil_wready  = wready_q;
    assign s_axil.s_axil_bresp   = bresp_q;
    assign s_axil.s_axil_bvalid  = bvalid_q;
    assign s_axil.s_axil_arready = arready_q;
    assign s_axil.s_axil_rdata   = rdata_q;
    assign s_axil.s_axil_rresp   = rresp_q;
    assign s_axil.s_axil_rvalid  = rvalid_q;
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Self-checking bench for axi_lite_slave_mem: directed cases plus randomized
// traffic compared against a word-array reference model.
module tb_axi_lite_slave_mem;
    localparam logic [31:0] OFF   = 32'h4000_0000;
    localparam logic [31:0] RNG   = 32'h0000_FFFF;
    localparam int          DEPTH = 256;
    localparam int          D     = 2;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   edge_cnt = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [31:0] model [DEPTH];

    axi_lite_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_slave_mem #(
        .AXI_DATA_WIDTH (32),
        .AXI_ADDR_WIDTH (32),
        .AXI_ADDR_OFFSET(OFF),
        .AXI_ADDR_RANGE (RNG),
        .MEM_DEPTH      (DEPTH),
        .RESP_DELAY     (D)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .s_axil (bus)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) edge_cnt <= edge_cnt + 1;

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference decode in plain 64-bit arithmetic.
    function automatic logic [1:0] ref_resp(input logic [31:0] addr);
        longint a, off;
        a   = longint'(addr);
        off = longint'(OFF);
        if (a < off || a > off + longint'(RNG)) return 2'b11;
        if ((a - off) / 4 >= DEPTH) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int ref_idx(input logic [31:0] addr);
        return int'((longint'(addr) - longint'(OFF)) / 4);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        if (ref_resp(addr) != 2'b00) return 32'h0;
        return model[ref_idx(addr)];
    endfunction

    function automatic void ref_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (ref_resp(addr) == 2'b00) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model[ref_idx(addr)][8*b +: 8] = data[8*b +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        logic [31:0] lo;
        sel = $urandom_range(0, 7);
        lo  = 32'($urandom_range(0, 3));
        case (sel)
            0, 1, 2, 3: return OFF + 32'($urandom_range(0, 15)) * 32'd4 + lo;
            4:          return OFF + 32'd1020 + lo;
            5:          return OFF + 32'(DEPTH * 4) + 32'($urandom_range(0, 1000)) * 32'd4 + lo;
            6:          return OFF - 32'd1 - 32'($urandom_range(0, 99));
            default:    return OFF + RNG + 32'd1 + 32'($urandom_range(0, 99));
        endcase
    endfunction

    // Called right after a falling edge; returns after the B handshake.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             output logic [1:0] resp, output int commit_edge);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc, lat;
        aw_done = 0; w_done = 0; cyc = 0; commit_edge = -1;
        bus.s_axil_awaddr = addr;
        bus.s_axil_wdata  = data;
        bus.s_axil_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 60) begin
            bus.s_axil_awvalid = !aw_done && (cyc >= aw_dly);
            bus.s_axil_wvalid  = !w_done && (cyc >= w_dly);
            aw_fire = bus.s_axil_awvalid && bus.s_axil_awready;
            w_fire  = bus.s_axil_wvalid && bus.s_axil_wready;
            @(negedge aclk);
            if (aw_fire || w_fire) commit_edge = edge_cnt;
            aw_done |= aw_fire;
            w_done  |= w_fire;
            cyc++;
        end
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wvalid  = 1'b0;
        check_eq("w_accept", {30'd0, aw_done, w_done}, 32'd3);
        lat = 0;
        while (!bus.s_axil_bvalid && lat < 40) begin
            @(negedge aclk);
            lat++;
        end
        check_eq("b_latency", lat, 1 + D);
        resp = bus.s_axil_bresp;
        repeat (b_dly) begin
            @(negedge aclk);
            check_eq("b_hold_valid", bus.s_axil_bvalid, 1'b1);
            check_eq("b_hold_resp", bus.s_axil_bresp, resp);
        end
        bus.s_axil_bready = 1'b1;
        @(negedge aclk);
        bus.s_axil_bready = 1'b0;
        check_eq("b_done", bus.s_axil_bvalid, 1'b0);
        check_eq("aw_ready_again", {bus.s_axil_awready, bus.s_axil_wready}, 2'b11);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp, output int sample_edge);
        int cyc, lat;
        repeat (ar_dly) @(negedge aclk);
        bus.s_axil_araddr  = addr;
        bus.s_axil_arvalid = 1'b1;
        cyc = 0;
        while (!bus.s_axil_arready && cyc < 40) begin
            @(negedge aclk);
            cyc++;
        end
        check_eq("ar_accept", bus.s_axil_arready, 1'b1);
        @(negedge aclk);
        bus.s_axil_arvalid = 1'b0;
        lat = 0;
        while (!bus.s_axil_rvalid && lat < 40) begin
            @(negedge aclk);
            lat++;
        end
        check_eq("r_latency", lat, 1 + D);
        sample_edge = edge_cnt;
        data = bus.s_axil_rdata;
        resp = bus.s_axil_rresp;
        repeat (r_dly) begin
            @(negedge aclk);
            check_eq("r_hold_valid", bus.s_axil_rvalid, 1'b1);
            check_eq("r_hold_data", bus.s_axil_rdata, data);
            check_eq("r_hold_resp", bus.s_axil_rresp, resp);
        end
        bus.s_axil_rready = 1'b1;
        @(negedge aclk);
        bus.s_axil_rready = 1'b0;
        check_eq("r_done", bus.s_axil_rvalid, 1'b0);
        check_eq("ar_ready_again", bus.s_axil_arready, 1'b1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] r;
        int ce;
        axi_write(addr, data, strb, aw_dly, w_dly, b_dly, r, ce);
        check_eq("bresp", r, ref_resp(addr));
        ref_write(addr, data, strb);
    endtask

    task automatic do_read(input logic [31:0] addr, input int ar_dly, input int r_dly, output logic [31:0] data);
        logic [1:0] r;
        int se;
        axi_read(addr, ar_dly, r_dly, data, r, se);
        check_eq("rresp", r, ref_resp(addr));
        check_eq("rdata", data, ref_read(addr));
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_awready", bus.s_axil_awready, 1'b0);
        check_eq("rst_wready", bus.s_axil_wready, 1'b0);
        check_eq("rst_arready", bus.s_axil_arready, 1'b0);
        check_eq("rst_bvalid", bus.s_axil_bvalid, 1'b0);
        check_eq("rst_rvalid", bus.s_axil_rvalid, 1'b0);
        check_eq("rst_bresp", bus.s_axil_bresp, 2'b00);
        check_eq("rst_rresp", bus.s_axil_rresp, 2'b00);
        check_eq("rst_rdata", bus.s_axil_rdata, 32'h0);
    endtask

    logic [31:0] rd, old_v, exp_v, waddr, raddr, wdat;
    logic [1:0]  wr, rr;
    logic [3:0]  strb;
    int          ce, se, kind, awd, wd, bd, ard, rdl;

    initial begin
        bus.s_axil_awaddr = 32'h0; bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wdata = 32'h0; bus.s_axil_wstrb = 4'h0; bus.s_axil_wvalid = 1'b0;
        bus.s_axil_bready = 1'b0;
        bus.s_axil_araddr = 32'h0; bus.s_axil_arvalid = 1'b0;
        bus.s_axil_rready = 1'b0;

        repeat (3) @(negedge aclk);
        check_reset_outputs();
        aresetn = 1'b1;
        @(negedge aclk);
        check_eq("ready_after_reset", {29'd0, bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready}, 32'd7);

        for (int i = 0; i < 16; i++) do_write(OFF + 32'(4 * i), $urandom | 32'h1, 4'hF, 0, 0, 0);
        do_write(OFF + 32'd1020, $urandom, 4'hF, 0, 0, 0);

        // Basic write/readback, then W leading AW with a partial strobe.
        do_write(OFF + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read(OFF + 32'h10, 0, 0, rd);
        check_eq("rd_deadbeef", rd, 32'hDEAD_BEEF);
        do_write(OFF + 32'h10, 32'h1122_3344, 4'b0101, 4, 0, 0);
        do_read(OFF + 32'h10, 0, 0, rd);
        check_eq("rd_strobe_merge", rd, 32'hDE22_BE44);

        // Error windows.
        axi_read(OFF + 32'(4 * DEPTH), 0, 0, rd, rr, se);
        check_eq("slverr_resp", rr, 2'b10);
        check_eq("slverr_data", rd, 32'h0);
        axi_write(OFF + RNG + 32'd1, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, wr, ce);
        check_eq("decerr_resp", wr, 2'b11);
        do_read(OFF + 32'h10, 0, 0, rd);
        check_eq("decerr_no_change", rd, 32'hDE22_BE44);

        // Write commit and read sample land on the same edge; long ready stalls.
        old_v = ref_read(OFF + 32'h10);
        fork
            axi_write(OFF + 32'h10, 32'hA5A5_5A5A, 4'hF, 3, 3, 10, wr, ce);
            axi_read(OFF + 32'h10, 0, 10, rd, rr, se);
        join
        check_eq("coinc_bresp", wr, 2'b00);
        check_eq("coinc_rresp", rr, 2'b00);
        check_eq("coinc_edges", se, ce);
        check_eq("coinc_old_data", rd, old_v);
        ref_write(OFF + 32'h10, 32'hA5A5_5A5A, 4'hF);
        do_read(OFF + 32'h10, 0, 0, rd);

        // Reset while waiting to respond; rdata is non-zero going in.
        do_read(OFF, 0, 0, rd);
        bus.s_axil_awaddr = OFF + 32'h20; bus.s_axil_wdata = model[8]; bus.s_axil_wstrb = 4'hF;
        bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1;
        @(negedge aclk);
        bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0;
        #2 aresetn = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check_eq("ready_after_rerelease", {bus.s_axil_awready, bus.s_axil_wready}, 2'b11);
        repeat (6) begin
            @(negedge aclk);
            check_eq("no_stale_b", bus.s_axil_bvalid, 1'b0);
        end
        do_read(OFF + 32'h20, 0, 0, rd);

        // Reset with only AW captured: the pending W must never land.
        bus.s_axil_awaddr = OFF + 32'h24; bus.s_axil_awvalid = 1'b1;
        @(negedge aclk);
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wdata = ~model[9]; bus.s_axil_wstrb = 4'hF; bus.s_axil_wvalid = 1'b1;
        #2 aresetn = 1'b0;
        #1 check_eq("rst_mid_wready", bus.s_axil_wready, 1'b0);
        @(negedge aclk);
        bus.s_axil_wvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            check_eq("no_b_uncommitted", bus.s_axil_bvalid, 1'b0);
        end
        do_read(OFF + 32'h24, 0, 0, rd);

        // Randomized traffic, including overlapping write/read pairs.
        for (int it = 0; it < 40; it++) begin
            kind  = int'($urandom_range(0, 2));
            waddr = rand_addr();
            raddr = ($urandom_range(0, 1) == 0) ? waddr : rand_addr();
            wdat  = $urandom;
            strb  = 4'($urandom_range(0, 15));
            awd = int'($urandom_range(0, 3)); wd = int'($urandom_range(0, 3)); bd = int'($urandom_range(0, 3));
            ard = int'($urandom_range(0, 6)); rdl = int'($urandom_range(0, 3));
            case (kind)
                0: do_write(waddr, wdat, strb, awd, wd, bd);
                1: do_read(raddr, ard, rdl, rd);
                default: begin
                    old_v = ref_read(raddr);
                    fork
                        axi_write(waddr, wdat, strb, awd, wd, bd, wr, ce);
                        axi_read(raddr, ard, rdl, rd, rr, se);
                    join
                    check_eq("rnd_bresp", wr, ref_resp(waddr));
                    check_eq("rnd_rresp", rr, ref_resp(raddr));
                    ref_write(waddr, wdat, strb);
                    exp_v = (se > ce) ? ref_read(raddr) : old_v;
                    check_eq("rnd_rdata", rd, exp_v);
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
